// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-input, W-bit valid/ready stream multiplexer.
// A round-robin arbiter picks one producer per cycle. The winning beat lands
// in a single registered output stage that supports backpressure.
// Optional packet lock is built only when STREAM_MUX_PKT_LOCK_EN is defined.
// With the lock, a channel keeps the grant from its first beat until its
// in_last beat. Without the macro, in_last is only forwarded to out_last.
// Ports are identical in both builds.

module stream_mux_rr #(
  parameter int N_CH = 4,
  parameter int W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*W-1:0]       in_data,
  input  logic [N_CH-1:0]         in_last,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  output logic [W-1:0]            out_data,
  output logic [$clog2(N_CH)-1:0] out_sel,
  output logic                    out_last,
  input  logic                    out_ready
);

  localparam int SEL_W = $clog2(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  // Output stage registers and their next values.
  logic             out_valid_reg, out_valid_next;
  logic [W-1:0]     out_data_reg,  out_data_next;
  logic [SEL_W-1:0] out_sel_reg,   out_sel_next;
  logic             out_last_reg,  out_last_next;

  // The round-robin pointer marks the first channel to be considered next cycle.
  logic [SEL_W-1:0] ptr_reg, ptr_next;

  // Arbitration signals.
  logic [W-1:0]     ch_data [N_CH];
  logic [N_CH-1:0]  ptr_mask;
  logic [N_CH-1:0]  req_hi;
  logic             hi_found, any_found;
  logic [SEL_W-1:0] hi_idx, any_idx;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_found;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] grant_succ;
  logic             load;
  logic             xfer;

  // The output register can take a beat when it is empty or being drained.
  assign load = ~out_valid_reg | out_ready;
  assign xfer = load & grant_found;

  // Per-channel slicing, pointer mask and one-hot ready generation.
  // in_ready is held low during reset, so no producer sees a handshake
  // for a beat that the reset would drop.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*W +: W];
      assign ptr_mask[gi] = (SEL_W'(gi) >= ptr_reg);
      assign in_ready[gi] = rst_n & xfer & (grant_idx == SEL_W'(gi));
    end
  endgenerate

  // The upper half holds the requests at or above ptr. They win over the
  // lower half, which gives the wrap-around search order ptr, ptr+1, ... 0, ...
  assign req_hi = in_valid & ptr_mask;

  // Find the lowest requester in the masked half and in the full request set.
  always_comb begin
    hi_found  = 1'b0;
    hi_idx    = '0;
    any_found = 1'b0;
    any_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_hi[i]) begin
        hi_found = 1'b1;
        hi_idx   = SEL_W'(i);
      end
      if (in_valid[i]) begin
        any_found = 1'b1;
        any_idx   = SEL_W'(i);
      end
    end
  end

  assign rr_found = any_found;
  assign rr_idx   = hi_found ? hi_idx : any_idx;

  // The pointer after serving the granted channel. It wraps explicitly at
  // N_CH-1, so unused index codes never appear when N_CH is not a power of two.
  assign grant_succ = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic lock_reg, lock_next;

  // While locked, only the channel that owns the open packet may be granted.
  // out_sel_reg always names that channel, because its beat was the last one
  // accepted.
  always_comb begin
    grant_found = rr_found;
    grant_idx   = rr_idx;
    if (lock_reg) begin
      grant_found = in_valid[out_sel_reg];
      grant_idx   = out_sel_reg;
    end
  end

  // A non-last beat opens or keeps the lock. A last beat releases the lock
  // and moves the pointer past the channel.
  always_comb begin
    lock_next = lock_reg;
    ptr_next  = ptr_reg;
    if (xfer) begin
      lock_next = ~in_last[grant_idx];
      if (in_last[grant_idx]) begin
        ptr_next = grant_succ;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg <= 1'b0;
    end else begin
      lock_reg <= lock_next;
    end
  end
`else
  // Arbitration is per beat: the arbiter result is used directly.
  assign grant_found = rr_found;
  assign grant_idx   = rr_idx;

  // Every accepted beat moves the pointer past its channel.
  always_comb begin
    ptr_next = ptr_reg;
    if (xfer) begin
      ptr_next = grant_succ;
    end
  end
`endif

  // Next state of the output stage. It loads the granted beat, empties when
  // nothing is offered, and holds while stalled.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_sel_next   = out_sel_reg;
    out_last_next  = out_last_reg;
    if (load) begin
      out_valid_next = grant_found;
      if (grant_found) begin
        out_data_next = ch_data[grant_idx];
        out_sel_next  = grant_idx;
        out_last_next = in_last[grant_idx];
      end
    end
  end

  // Output stage and pointer registers. A reset drops any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_last_reg  <= 1'b0;
      ptr_reg       <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_sel_reg   <= out_sel_next;
      out_last_reg  <= out_last_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_last  = out_last_reg;

  // Handshake invariants: at most one ready, none while stalled, and a
  // stalled beat stays put.
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready));
  a_no_ready_stalled : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_reg && !out_ready) |-> (in_ready == '0));
  a_hold_stalled : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_reg && !out_ready) |=>
      (out_valid_reg && $stable(out_data_reg) && $stable(out_sel_reg) && $stable(out_last_reg)));

endmodule
